// File: rtl/ascon_block_packer.sv
// ascon_block_packer: packs an AD/PT byte stream into 64-bit big-endian
// Ascon rate blocks with 0x80-then-zeros padding, double-buffered behind a
// valid/ready output so the byte source can run ahead of the core.
// Optional block counter output enabled by defining ASCON_PACK_CNT_EN.
module ascon_block_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h80
`ifdef ASCON_PACK_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    input  logic        byte_last_i,
    input  logic        byte_type_i,
    output logic        byte_ready_o,
    input  logic        empty_i,
    output logic [63:0] block_o,
    output logic        block_valid_o,
    input  logic        block_ready_i,
    output logic        block_last_o,
    output logic        block_type_o,
    output logic        err_o
`ifdef ASCON_PACK_CNT_EN
    ,
    output logic [CNT_W-1:0] blk_count_o
`endif
);

    localparam logic [63:0] PAD_BLOCK = {PAD_BYTE, 56'h0};

    logic [63:0] asm_reg;
    logic [63:0] asm_fill;
    logic [3:0]  cnt;
    logic        seg_type;
    logic        pending;
    logic        last;
    logic        pad_pending;

    logic        byte_accept;
    logic        transfer;
    logic        empty_ok;
    logic        type_err;
    logic        empty_err;

    // The assembly side only takes bytes while nothing is waiting to move out.
    assign byte_ready_o = !pending && !pad_pending;
    assign byte_accept  = byte_valid_i && byte_ready_o;
    assign transfer     = pending && (!block_valid_o || block_ready_i);
    assign empty_ok     = empty_i && !byte_accept && (cnt == 4'd0) && !pending && !pad_pending;
    assign empty_err    = empty_i && !empty_ok;
    assign type_err     = byte_accept && (cnt != 4'd0) && (byte_type_i != seg_type);

    // Assembly word after writing the incoming byte; a final byte also drops
    // the pad byte right behind it and zeroes the rest of the block.
    always_comb begin
        asm_fill = asm_reg;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) == cnt) begin
                asm_fill[63-8*i -: 8] = byte_i;
            end else if (byte_last_i && (4'(i) == cnt + 4'd1)) begin
                asm_fill[63-8*i -: 8] = PAD_BYTE;
            end else if (byte_last_i && (4'(i) > cnt + 4'd1)) begin
                asm_fill[63-8*i -: 8] = 8'h00;
            end
        end
    end

    // Assembly register, byte count and the pending / pad-follow-up flags.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            asm_reg     <= '0;
            cnt         <= '0;
            seg_type    <= 1'b0;
            pending     <= 1'b0;
            last        <= 1'b0;
            pad_pending <= 1'b0;
        end else if (clear_i) begin
            asm_reg     <= '0;
            cnt         <= '0;
            seg_type    <= 1'b0;
            pending     <= 1'b0;
            last        <= 1'b0;
            pad_pending <= 1'b0;
        end else if (transfer) begin
            if (pad_pending) begin
                asm_reg     <= PAD_BLOCK;
                last        <= 1'b1;
                pad_pending <= 1'b0;
            end else begin
                asm_reg <= '0;
                cnt     <= '0;
                pending <= 1'b0;
                last    <= 1'b0;
            end
        end else if (byte_accept) begin
            asm_reg <= asm_fill;
            cnt     <= cnt + 4'd1;
            if (cnt == 4'd0) begin
                seg_type <= byte_type_i;
            end
            if (cnt == 4'd7) begin
                pending     <= 1'b1;
                last        <= 1'b0;
                pad_pending <= byte_last_i;
            end else if (byte_last_i) begin
                pending <= 1'b1;
                last    <= 1'b1;
            end
        end else if (empty_ok) begin
            asm_reg  <= PAD_BLOCK;
            last     <= 1'b1;
            seg_type <= byte_type_i;
            pending  <= 1'b1;
        end
    end

    // Output register: loads on transfer, drops valid once accepted and idle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            block_o       <= '0;
            block_valid_o <= 1'b0;
            block_last_o  <= 1'b0;
            block_type_o  <= 1'b0;
        end else if (clear_i) begin
            block_o       <= '0;
            block_valid_o <= 1'b0;
            block_last_o  <= 1'b0;
            block_type_o  <= 1'b0;
        end else if (transfer) begin
            block_o       <= asm_reg;
            block_valid_o <= 1'b1;
            block_last_o  <= last;
            block_type_o  <= seg_type;
        end else if (block_valid_o && block_ready_i) begin
            block_valid_o <= 1'b0;
        end
    end

    // Sticky protocol error: type change mid-block or an unusable empty_i.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            err_o <= 1'b0;
        end else if (clear_i) begin
            err_o <= 1'b0;
        end else if (type_err || empty_err) begin
            err_o <= 1'b1;
        end
    end

`ifdef ASCON_PACK_CNT_EN
    // Counts completed output handshakes, wrapping naturally.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            blk_count_o <= '0;
        end else if (clear_i) begin
            blk_count_o <= '0;
        end else if (block_valid_o && block_ready_i) begin
            blk_count_o <= blk_count_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ascon_block_packer.sv
// Testbench for ascon_block_packer: directed test-plan segments plus random
// segments, checked against a segment-level padding model and a scoreboard.
module tb_ascon_block_packer;

    localparam logic [7:0] PAD = 8'h80;

    logic        clock_i;
    logic        reset_i;
    logic        clear_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_last_i;
    logic        byte_type_i;
    logic        byte_ready_o;
    logic        empty_i;
    logic [63:0] block_o;
    logic        block_valid_o;
    logic        block_ready_i;
    logic        block_last_o;
    logic        block_type_o;
    logic        err_o;
`ifdef ASCON_PACK_CNT_EN
    logic [15:0] blk_count_o;
`endif

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int ready_policy = 0;
    int cycle = 0;
    logic [65:0] exp_q[$];

    ascon_block_packer dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .clear_i       (clear_i),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_last_i   (byte_last_i),
        .byte_type_i   (byte_type_i),
        .byte_ready_o  (byte_ready_o),
        .empty_i       (empty_i),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_ready_i (block_ready_i),
        .block_last_o  (block_last_o),
        .block_type_o  (block_type_o),
        .err_o         (err_o)
`ifdef ASCON_PACK_CNT_EN
        ,
        .blk_count_o   (blk_count_o)
`endif
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) cycle++;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic push_exp(input logic [63:0] blk, input logic lst, input logic typ);
        exp_q.push_back({typ, lst, blk});
    endtask

    // Reference: append the pad byte, zero-fill to a multiple of 8, cut into blocks.
    task automatic model_segment(input logic [7:0] seg[$], input logic typ);
        logic [7:0]  padded[$];
        logic [63:0] blk;
        int          nblk;
        padded = seg;
        padded.push_back(PAD);
        while (padded.size() % 8 != 0) padded.push_back(8'h00);
        nblk = padded.size() / 8;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int j = 0; j < 8; j++) blk = {blk[55:0], padded[b*8+j]};
            push_exp(blk, (b == nblk - 1), typ);
        end
    endtask

    // Consumer side: drives block_ready_i and scores every completed handshake.
    always @(negedge clock_i) begin
        logic [65:0] e;
        case (ready_policy)
            0:       block_ready_i = 1'b1;
            1:       block_ready_i = ($urandom_range(0, 3) != 0);
            default: block_ready_i = 1'b0;
        endcase
        if (!reset_i && !clear_i && block_valid_o && block_ready_i) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                checkOutput("spurious_block", 64'(block_valid_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("block", block_o, e[63:0]);
                checkOutput("block_last", 64'(block_last_o), 64'(e[64]));
                checkOutput("block_type", 64'(block_type_o), 64'(e[65]));
            end
        end
    end

    // Sends one segment (or an empty_i pulse for a zero-length one).
    task automatic applyStimulus(input logic [7:0] seg[$], input logic typ, input int flip_idx,
                                 input int gap_max, input logic send_last);
        int  waited;
        int  gap;
        bit  accepted;
        if (seg.size() == 0) begin
            waited = 0;
            @(negedge clock_i);
            while (!byte_ready_o && waited < 300) begin
                @(negedge clock_i);
                waited++;
            end
            if (waited >= 300) begin
                checkOutput("empty_timeout", 64'(waited), 64'd0);
                return;
            end
            empty_i     = 1'b1;
            byte_type_i = typ;
            @(negedge clock_i);
            empty_i = 1'b0;
            return;
        end
        for (int i = 0; i < seg.size(); i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clock_i);
                byte_valid_i = 1'b0;
            end
            accepted = 0;
            waited   = 0;
            while (!accepted) begin
                @(negedge clock_i);
                byte_valid_i = 1'b1;
                byte_i       = seg[i];
                byte_last_i  = send_last && (i == seg.size() - 1);
                byte_type_i  = (i == flip_idx) ? ~typ : typ;
                if (byte_ready_o) begin
                    accepted = 1;
                end else begin
                    waited++;
                    if (waited > 300) begin
                        checkOutput("byte_timeout", 64'(waited), 64'd0);
                        byte_valid_i = 1'b0;
                        return;
                    end
                end
            end
        end
        @(negedge clock_i);
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(negedge clock_i);
            waited++;
        end
        @(negedge clock_i);
        checkOutput("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] q[$];
        string      s;
        int         start;
        int         len;
        logic       typ;

        reset_i      = 1'b1;
        clear_i      = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        byte_type_i  = 1'b0;
        empty_i      = 1'b0;
        block_ready_i = 1'b1;

        repeat (3) @(negedge clock_i);
        checkOutput("rst_block", block_o, 64'h0);
        checkOutput("rst_valid", 64'(block_valid_o), 64'd0);
        checkOutput("rst_last", 64'(block_last_o), 64'd0);
        checkOutput("rst_type", 64'(block_type_o), 64'd0);
        checkOutput("rst_err", 64'(err_o), 64'd0);
        reset_i = 1'b0;
        @(negedge clock_i);
        checkOutput("rst_ready", 64'(byte_ready_o), 64'd1);

        $display("[TB] AD 2023");
        q = '{8'h32, 8'h30, 8'h32, 8'h33};
        push_exp(64'h3230323380000000, 1'b1, 1'b0);
        applyStimulus(q, 1'b0, -1, 2, 1'b1);
        waitDrain();

        $display("[TB] PT sentence");
        ready_policy = 1;
        s = "Concevez ASCON en SystemVerilog";
        q.delete();
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        push_exp(64'h436F6E636576657A, 1'b0, 1'b1);
        push_exp(64'h204153434F4E2065, 1'b0, 1'b1);
        push_exp(64'h6E2053797374656D, 1'b0, 1'b1);
        push_exp(64'h566572696C6F6780, 1'b1, 1'b1);
        applyStimulus(q, 1'b1, -1, 1, 1'b1);
        waitDrain();

        $display("[TB] full block plus pad block, latency");
        ready_policy = 0;
        q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        push_exp(64'h0001020304050607, 1'b0, 1'b1);
        push_exp(64'h8000000000000000, 1'b1, 1'b1);
        applyStimulus(q, 1'b1, -1, 0, 1'b1);
        checkOutput("lat_valid_early", 64'(block_valid_o), 64'd0);
        checkOutput("lat_ready_low", 64'(byte_ready_o), 64'd0);
        @(negedge clock_i);
        checkOutput("lat_valid", 64'(block_valid_o), 64'd1);
        checkOutput("lat_block", block_o, 64'h0001020304050607);
        waitDrain();

        $display("[TB] output stall");
        ready_policy = 2;
        start = cycle;
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(8'(8'h10 + i));
        push_exp(64'h1011121314151617, 1'b0, 1'b0);
        push_exp(64'h18191A1B1C1D1E1F, 1'b0, 1'b0);
        applyStimulus(q, 1'b0, -1, 0, 1'b0);
        while (cycle - start < 20) begin
            @(negedge clock_i);
            checkOutput("stall_hold", block_o, 64'h1011121314151617);
        end
        checkOutput("stall_valid", 64'(block_valid_o), 64'd1);
        checkOutput("stall_byte_ready", 64'(byte_ready_o), 64'd0);
        @(posedge clock_i);
        #1 ready_policy = 0;
        @(negedge clock_i);
        @(negedge clock_i);
        checkOutput("release_valid", 64'(block_valid_o), 64'd1);
        checkOutput("release_block", block_o, 64'h18191A1B1C1D1E1F);
        waitDrain();

        $display("[TB] empty segment and misuse");
        q.delete();
        push_exp(64'h8000000000000000, 1'b1, 1'b1);
        applyStimulus(q, 1'b1, -1, 0, 1'b1);
        waitDrain();
        checkOutput("empty_no_err", 64'(err_o), 64'd0);
        q = '{8'hA1, 8'hA2, 8'hA3};
        applyStimulus(q, 1'b0, -1, 0, 1'b0);
        empty_i     = 1'b1;
        byte_type_i = 1'b0;
        @(negedge clock_i);
        empty_i = 1'b0;
        @(negedge clock_i);
        checkOutput("empty_err", 64'(err_o), 64'd1);
        repeat (3) @(negedge clock_i);
        checkOutput("empty_no_block", 64'(block_valid_o), 64'd0);

        $display("[TB] reset mid-segment");
        q = '{8'hA4, 8'hA5};
        applyStimulus(q, 1'b0, -1, 0, 1'b0);
        reset_i = 1'b1;
        exp_q.delete();
        hs_count = 0;
        @(negedge clock_i);
        checkOutput("mid_rst_block", block_o, 64'h0);
        checkOutput("mid_rst_valid", 64'(block_valid_o), 64'd0);
        checkOutput("mid_rst_last", 64'(block_last_o), 64'd0);
        checkOutput("mid_rst_type", 64'(block_type_o), 64'd0);
        checkOutput("mid_rst_err", 64'(err_o), 64'd0);
        reset_i = 1'b0;
        @(negedge clock_i);
        checkOutput("mid_rst_ready", 64'(byte_ready_o), 64'd1);
        q = '{8'hAA};
        push_exp(64'hAA80000000000000, 1'b1, 1'b0);
        applyStimulus(q, 1'b0, -1, 0, 1'b1);
        waitDrain();

        $display("[TB] type mismatch and clear");
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        model_segment(q, 1'b1);
        applyStimulus(q, 1'b1, 2, 0, 1'b1);
        waitDrain();
        checkOutput("type_err", 64'(err_o), 64'd1);
        clear_i = 1'b1;
        @(negedge clock_i);
        clear_i = 1'b0;
        hs_count = 0;
        @(negedge clock_i);
        checkOutput("clr_err", 64'(err_o), 64'd0);
        checkOutput("clr_block", block_o, 64'h0);
        checkOutput("clr_valid", 64'(block_valid_o), 64'd0);
        checkOutput("clr_ready", 64'(byte_ready_o), 64'd1);

        $display("[TB] random segments");
        ready_policy = 1;
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(0, 20);
            typ = 1'($urandom_range(0, 1));
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            model_segment(q, typ);
            applyStimulus(q, typ, -1, 2, 1'b1);
        end
        waitDrain();
        checkOutput("rand_no_err", 64'(err_o), 64'd0);

`ifdef ASCON_PACK_CNT_EN
        @(negedge clock_i);
        checkOutput("blk_count", 64'(blk_count_o), 64'(hs_count[15:0]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascon_block_packer.md
Name: ascon_block_packer

Overview:
- Upstream feeder for the Ascon128 core.
- Takes a byte stream of associated data (AD) and plaintext (PT), packs the bytes big-endian into 64-bit rate blocks and applies Ascon padding (0x80 then zeros).
- Presents finished blocks on a valid/ready interface. A thin adapter converts this into the core's data_i/data_valid_i.
- Double-buffered: one assembly register plus one output register, so a byte source can run ahead while the core is busy permuting.

Parameters:
- PAD_BYTE, 8'h80, byte inserted directly after the last message byte.
- CNT_W, 16, width of the optional block counter.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous active-high reset.
- clear_i  in  1  synchronous clear of all state, including err_o. Same effect as reset.
- byte_i  in  8  message byte.
- byte_valid_i  in  1  byte_i is valid.
- byte_last_i  in  1  byte_i is the final byte of the current segment.
- byte_type_i  in  1  segment type: 0 = AD, 1 = PT.
- byte_ready_o  out  1  packer can accept a byte this cycle.
- empty_i  in  1  one-cycle pulse requesting a pad-only block for an empty segment, typed by byte_type_i.
- block_o  out  64  packed block. First byte of the block sits in bits [63:56].
- block_valid_o  out  1  block_o is valid.
- block_ready_i  in  1  consumer accepts block_o.
- block_last_o  out  1  block carries the padding, i.e. it is the final block of its segment.
- block_type_o  out  1  segment type of block_o.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset and clear (either one, including mid-segment): all internal state cleared.
  - block_o = 0, block_valid_o = 0, block_last_o = 0, block_type_o = 0, err_o = 0.
  - Byte count = 0, pending = 0, pad_pending = 0.
  - byte_ready_o = 1 one cycle after release of reset/clear.
  - Any partial block is discarded.
- Internal state: assembly register asm[63:0], byte count cnt (0..8), type latch, flags pending, last and pad_pending.
- byte_ready_o = !pending && !pad_pending.
- Byte accept (byte_valid_i && byte_ready_o):
  - asm[63-8*cnt -: 8] <= byte_i; cnt <= cnt+1.
  - Type is latched when cnt == 0.
  - If cnt > 0 and byte_type_i differs from the latched type: err_o <= 1. The byte is still accepted under the latched type.
- Block completion, judged on the accepted byte:
  - cnt+1 == 8 and not last: pending = 1, last = 0.
  - cnt+1 < 8 and last: PAD_BYTE written at position cnt+1, remaining bytes zero, pending = 1, last = 1.
  - cnt+1 == 8 and last: pending = 1, last = 0, pad_pending = 1. The follow-up block is {PAD_BYTE, 56'h0}, last = 1, same type.
- empty_i:
  - Honoured only when cnt == 0 and neither pending flag is set. It then loads asm = {PAD_BYTE, 56'h0}, last = 1, type = byte_type_i, pending = 1.
  - Otherwise it is ignored and err_o <= 1.
  - empty_i together with an accepted byte in the same cycle: the byte wins and err_o <= 1.
- Transfer to output, at the edge where pending && (!block_valid_o || block_ready_i):
  - block_o, last and type are loaded from asm; block_valid_o <= 1.
  - If pad_pending: asm <= pad block, pending stays 1, pad_pending <= 0.
  - Else: asm <= 0, cnt <= 0, pending <= 0.
- Output handshake:
  - block_valid_o is held, with block_o/last/type stable, until block_ready_i is sampled high.
  - On accept with nothing pending, block_valid_o <= 0 the next edge.
  - Back-to-back transfer in the same edge as an accept is permitted.
- Latency and throughput:
  - Completing byte accepted at edge k → block_valid_o high after edge k+1, given the output is free.
  - Sustained throughput is 8 bytes per 9 cycles, because byte_ready_o drops for one cycle per block.
- byte_ready_o stays low for as long as the output is full and a block is pending, i.e. backpressure propagates.

Optional Feature:
- Macro ASCON_PACK_CNT_EN.
- When defined:
  - Adds output port blk_count_o [CNT_W-1:0].
  - Counts completed output handshakes (block_valid_o && block_ready_i). Wraps modulo 2^CNT_W.
  - Cleared by reset_i and clear_i.
- When undefined: port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- AD "2023": bytes 32,30,32,33 type 0, last on 33 → one block 64'h3230323380000000, last = 1, type = 0.
- PT "Concevez ASCON en SystemVerilog" (31 bytes), type 1 → blocks 436F6E636576657A, 204153434F4E2065, 6E2053797374656D, 566572696C6F6780; last only on the 4th.
- 8-byte PT 00..07 with last on byte 07 → 0001020304050607 (last = 0), then 8000000000000000 (last = 1).
- block_ready_i held low for 20 cycles while 16 bytes arrive:
  - block_o holds the first block unchanged.
  - byte_ready_o drops after byte 16.
  - On release, the second block follows on the next edge.
- empty_i with type 1 while idle → 8000000000000000, last = 1, type = 1. empty_i with cnt = 3 → err_o = 1, no block emitted.
- reset_i pulse after 5 bytes of a segment → all outputs 0, partial block lost. A new 1-byte AD AA → AA80000000000000.
